// File: rtl/p1_stream_ctrl_pkg.sv
// Shared types and helpers for the p1 stream controller: state encoding,
// latency limit and the effective-length rule.
package p1_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int Y_LAT_MAX = 3;

  // A zero or oversized length means "send the whole pattern".
  function automatic int eff_len(input int len, input int pat_w);
    return ((len == 0) || (len > pat_w)) ? pat_w : len;
  endfunction

endpackage

// File: rtl/p1_stream_ctrl_if.sv
// Host-side run request and result bus of the p1 stream controller.
interface p1_stream_ctrl_if #(
  parameter int PAT_W = 16
);
  localparam int CNT_W = $clog2(PAT_W + 1);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] length;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic [PAT_W-1:0] hit_map;

  modport master (
    output start, pattern, length,
    input  busy, done, hit_count, hit_map
  );

  modport slave (
    input  start, pattern, length,
    output busy, done, hit_count, hit_map
  );
endinterface

// File: rtl/p1_lat_pipe.sv
// Y_LAT-deep delay line carrying {valid, idx} so each y_in sample is
// attributed to the pattern bit that caused it.
module p1_lat_pipe #(
  parameter int Y_LAT = 1,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  if (Y_LAT == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_vld = in_vld;
    assign out_idx = in_idx;
  end else begin : g_pipe
    logic [Y_LAT-1:0]            vld_p;
    logic [Y_LAT-1:0][IDX_W-1:0] idx_p;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= '0;
        idx_p <= '0;
      end else begin
        vld_p[0] <= in_vld;
        idx_p[0] <= in_idx;
        for (int k = 1; k < Y_LAT; k++) begin
          vld_p[k] <= vld_p[k-1];
          idx_p[k] <= idx_p[k-1];
        end
      end
    end

    assign out_vld = vld_p[Y_LAT-1];
    assign out_idx = idx_p[Y_LAT-1];
  end

endmodule

// File: rtl/p1_stream_ctrl.sv
// Shifts a latched pattern LSB-first into the p1 detector and collects its
// latency-aligned responses into a hit map and hit count.
module p1_stream_ctrl
  import p1_ctrl_pkg::*;
#(
  parameter int PAT_W = 16,
  parameter int Y_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  p1_stream_ctrl_if.slave      bus,
  output logic                 x_out,
  input  logic                 y_in
);

  localparam int CNT_W = $clog2(PAT_W + 1);

  state_e           state, state_n;
  logic [CNT_W-1:0] idx, idx_n;
  logic [1:0]       dcnt, dcnt_n;
  logic [CNT_W-1:0] len_q;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] pat_nx;
  logic             x_n, busy_q, busy_n, done_q, done_n;
  logic             accept, last;
  logic             pipe_vld;
  logic [CNT_W-1:0] pipe_idx;
  logic [CNT_W-1:0] hit_count_q;
  logic [PAT_W-1:0] hit_map_q;

  assign last   = (idx == len_q - 1'b1);
  assign pat_nx = pat_q >> (idx + 1'b1);

  // Outputs are registered, so they are computed from the next state.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dcnt_n  = dcnt;
    x_n     = 1'b0;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = ST_SHIFT;
          idx_n   = '0;
          x_n     = bus.pattern[0];
        end
      end
      ST_SHIFT: begin
        idx_n = idx + 1'b1;
        if (last) begin
          state_n = (Y_LAT > 0) ? ST_DRAIN : ST_DONE;
          dcnt_n  = '0;
        end else begin
          x_n = pat_nx[0];
        end
      end
      ST_DRAIN: begin
        dcnt_n = dcnt + 1'b1;
        if (dcnt == 2'(Y_LAT - 1)) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n == ST_SHIFT) || (state_n == ST_DRAIN);
    done_n = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      dcnt   <= '0;
      x_out  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      dcnt   <= dcnt_n;
      x_out  <= x_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pat_q <= bus.pattern;
      len_q <= CNT_W'(eff_len(int'(bus.length), PAT_W));
    end
  end

  p1_lat_pipe #(
    .Y_LAT (Y_LAT),
    .IDX_W (CNT_W)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (state == ST_SHIFT),
    .in_idx  (idx),
    .out_vld (pipe_vld),
    .out_idx (pipe_idx)
  );

  // Results survive DONE and are only cleared by the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q <= '0;
      hit_map_q   <= '0;
    end else if (accept) begin
      hit_count_q <= '0;
      hit_map_q   <= '0;
    end else if (pipe_vld && y_in) begin
      hit_count_q <= hit_count_q + 1'b1;
      hit_map_q   <= hit_map_q | (PAT_W'(1) << pipe_idx);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit_count = hit_count_q;
  assign bus.hit_map   = hit_map_q;

endmodule

// File: tb/tb_p1_stream_ctrl.sv
// Directed bench: a Mealy-style (Y_LAT=0) and a Moore-style (Y_LAT=1)
// controller driven from the same host stimulus.
module tb_p1_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  length = '0;
  logic        x0, y0, x1, y1, y1_q;

  int total = 0;
  int bad = 0;
  int bcnt[2];
  int dcyc[2];
  int dnum[2];

  always #5 clk = ~clk;

  p1_stream_ctrl_if #(.PAT_W(16)) bus0 ();
  p1_stream_ctrl_if #(.PAT_W(16)) bus1 ();

  assign bus0.start = start;
  assign bus0.pattern = pattern;
  assign bus0.length = length;
  assign bus1.start = start;
  assign bus1.pattern = pattern;
  assign bus1.length = length;

  assign y0 = x0;
  always @(posedge clk) y1_q <= x1;
  assign y1 = y1_q;

  p1_stream_ctrl #(.PAT_W(16), .Y_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .x_out(x0), .y_in(y0));
  p1_stream_ctrl #(.PAT_W(16), .Y_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .x_out(x1), .y_in(y1));

  // Starts a run (start sampled at edge 0) and observes 40 cycles;
  // at cycle "poke" a stray start with a zero pattern is injected.
  task automatic run(input logic [15:0] pat, input logic [4:0] len, input int poke);
    @(negedge clk);
    pattern = pat; length = len; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 2; i++) begin bcnt[i] = 0; dcyc[i] = 0; dnum[i] = 0; end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus0.busy) bcnt[0]++;
      if (bus1.busy) bcnt[1]++;
      if (bus0.done) begin dnum[0]++; if (dcyc[0] == 0) dcyc[0] = c; end
      if (bus1.done) begin dnum[1]++; if (dcyc[1] == 0) dcyc[1] = c; end
      if (c == poke) begin start = 1'b1; pattern = 16'h0000; end
      if (c == poke + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'($urandom); pattern = 16'($urandom); length = 5'($urandom);
      #1;
      total++;
      if ({bus0.busy, bus0.done, bus0.hit_count, bus0.hit_map, x0} !== 24'h0) begin
        bad++; $display("FAIL reset_dut0: got %h want 0", {bus0.busy, bus0.done, bus0.hit_count, bus0.hit_map, x0});
      end
      total++;
      if ({bus1.busy, bus1.done, bus1.hit_count, bus1.hit_map, x1} !== 24'h0) begin
        bad++; $display("FAIL reset_dut1: got %h want 0", {bus1.busy, bus1.done, bus1.hit_count, bus1.hit_map, x1});
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_mealy();
    run(16'h00FF, 5'd8, 0);
    total++; if (bcnt[0] !== 8) begin bad++; $display("FAIL mealy_busy: got %0d want 8", bcnt[0]); end
    total++; if (dcyc[0] !== 9) begin bad++; $display("FAIL mealy_done_cycle: got %0d want 9", dcyc[0]); end
    total++; if (dnum[0] !== 1) begin bad++; $display("FAIL mealy_done_count: got %0d want 1", dnum[0]); end
    total++; if (bus0.hit_count !== 5'd8) begin bad++; $display("FAIL mealy_hit_count: got %0d want 8", bus0.hit_count); end
    total++; if (bus0.hit_map !== 16'h00FF) begin bad++; $display("FAIL mealy_hit_map: got %h want 00ff", bus0.hit_map); end
    total++; if (x0 !== 1'b0) begin bad++; $display("FAIL mealy_idle_x: got %b want 0", x0); end
  endtask

  task automatic test_moore();
    run(16'hA5A5, 5'd0, 0);
    total++; if (bcnt[1] !== 17) begin bad++; $display("FAIL moore_busy: got %0d want 17", bcnt[1]); end
    total++; if (dcyc[1] !== 18) begin bad++; $display("FAIL moore_done_cycle: got %0d want 18", dcyc[1]); end
    total++; if (bus1.hit_count !== 5'd8) begin bad++; $display("FAIL moore_hit_count: got %0d want 8", bus1.hit_count); end
    total++; if (bus1.hit_map !== 16'hA5A5) begin bad++; $display("FAIL moore_hit_map: got %h want a5a5", bus1.hit_map); end
    total++; if (bcnt[0] !== 16) begin bad++; $display("FAIL full_len_busy: got %0d want 16", bcnt[0]); end
    total++; if (bus0.hit_map !== 16'hA5A5) begin bad++; $display("FAIL full_len_map: got %h want a5a5", bus0.hit_map); end
  endtask

  task automatic test_clamp();
    run(16'hFFFF, 5'd20, 0);
    total++; if (bus0.hit_count !== 5'd16) begin bad++; $display("FAIL clamp_hit_count: got %0d want 16", bus0.hit_count); end
    total++; if (bus0.hit_map !== 16'hFFFF) begin bad++; $display("FAIL clamp_hit_map: got %h want ffff", bus0.hit_map); end
    total++; if (dcyc[0] !== 17) begin bad++; $display("FAIL clamp_done_cycle: got %0d want 17", dcyc[0]); end
    run(16'h0001, 5'd1, 0);
    total++; if (bus0.hit_count !== 5'd1) begin bad++; $display("FAIL len1_hit_count: got %0d want 1", bus0.hit_count); end
    total++; if (bus0.hit_map !== 16'h0001) begin bad++; $display("FAIL len1_hit_map: got %h want 0001", bus0.hit_map); end
    total++; if (dcyc[0] !== 2) begin bad++; $display("FAIL len1_done_cycle: got %0d want 2", dcyc[0]); end
  endtask

  task automatic test_busy_protect();
    run(16'h00FF, 5'd8, 4);
    total++; if (dnum[0] !== 1) begin bad++; $display("FAIL protect_done_count: got %0d want 1", dnum[0]); end
    total++; if (dcyc[0] !== 9) begin bad++; $display("FAIL protect_done_cycle: got %0d want 9", dcyc[0]); end
    total++; if (bus0.hit_count !== 5'd8) begin bad++; $display("FAIL protect_hit_count: got %0d want 8", bus0.hit_count); end
    total++; if (bus0.hit_map !== 16'h00FF) begin bad++; $display("FAIL protect_hit_map: got %h want 00ff", bus0.hit_map); end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    pattern = 16'h00FF; length = 5'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({bus0.busy, bus0.done, bus0.hit_count, bus0.hit_map, x0} !== 24'h0) begin
      bad++; $display("FAIL abort_clear_dut0: got %h want 0", {bus0.busy, bus0.done, bus0.hit_count, bus0.hit_map, x0});
    end
    total++;
    if ({bus1.busy, bus1.done, bus1.hit_count, bus1.hit_map, x1} !== 24'h0) begin
      bad++; $display("FAIL abort_clear_dut1: got %h want 0", {bus1.busy, bus1.done, bus1.hit_count, bus1.hit_map, x1});
    end
    seen = 0;
    repeat (3) @(negedge clk) if (bus0.done || bus1.done) seen++;
    rst = 1'b0;
    repeat (20) @(negedge clk) if (bus0.done || bus1.done) seen++;
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", seen); end
    run(16'h000F, 5'd4, 0);
    total++; if (bus0.hit_count !== 5'd4) begin bad++; $display("FAIL post_abort_hit_count: got %0d want 4", bus0.hit_count); end
    total++; if (bus0.hit_map !== 16'h000F) begin bad++; $display("FAIL post_abort_hit_map: got %h want 000f", bus0.hit_map); end
    total++; if (dnum[0] !== 1) begin bad++; $display("FAIL post_abort_done_count: got %0d want 1", dnum[0]); end
  endtask

  initial begin
    test_reset();
    test_mealy();
    test_moore();
    test_clamp();
    test_busy_protect();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/p1_stream_ctrl.md
# p1_stream_ctrl

Sequencing controller for the `p1` serial detector, which takes a single input bit `X` per clock and produces `Y`. The block latches a bit pattern on `start` and drives it onto the detector's `X` input, one bit per cycle, LSB first. It samples the detector's `Y` output with a configurable latency and reports a per-bit hit map and a hit count. It sits between a test or host register interface and the `p1` instance, and owns `p1`'s input for the whole run.

## Interface
- `PAT_W`, default 16: maximum pattern length in bits; must be ≥ 2.
- `Y_LAT`, default 1: cycles from presenting a bit on `x_out` to its `y_in` response. 0 suits a Mealy detector, 1 a Moore detector; the legal range is 0..3.
- `CNT_W`, derived as `$clog2(PAT_W+1)`: width of the length and count fields. It is not user-overridable.

Ports:
- `clk`  in  1  single clock; every register is rising-edge triggered.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `pattern`  in  PAT_W  bits to send; latched on an accepted start.
- `length`  in  CNT_W  number of bits to send; latched on an accepted start.
- `x_out`  out  1  drives `p1.X`.
- `y_in`  in  1  from `p1.Y`.
- `busy`  out  1  high in SHIFT and DRAIN.
- `done`  out  1  one-cycle pulse at the end of a run.
- `hit_count`  out  CNT_W  number of sampled `y_in` highs in the current or last run.
- `hit_map`  out  PAT_W  bit i set when the response to pattern bit i was high.

## Operation
- States are IDLE, SHIFT, DRAIN and DONE.
- IDLE → SHIFT when `start`=1.
  - On that edge: latch `pattern` and the effective length, clear `hit_count`/`hit_map`, and zero the bit index.
  - The effective length L is PAT_W when `length`=0 or `length`>PAT_W; otherwise it is `length`.
- SHIFT:
  - `x_out` = latched `pattern[idx]`; `idx` increments every cycle.
  - After the cycle with idx = L−1, go to DRAIN if Y_LAT>0, otherwise to DONE.
- DRAIN: lasts exactly Y_LAT cycles with `x_out`=0, then goes to DONE.
- DONE: lasts one cycle with `done`=1, then returns to IDLE.
- Response sampling:
  - The `y_in` sample for bit i is taken in the cycle Y_LAT cycles after bit i was presented.
  - A high sample sets `hit_map[i]` and increments `hit_count`.
  - Samples are taken only for bits 0..L−1; `y_in` is ignored in every other cycle.
  - Alignment uses a Y_LAT-deep valid/index delay line.
- `start` while not in IDLE is ignored. Changes to `pattern`/`length` after acceptance have no effect.
- `hit_count`/`hit_map` hold their values after DONE until the next accepted start.
- `hit_count` never exceeds L ≤ PAT_W, so it cannot overflow CNT_W.

## Timing
- Reset values: state IDLE, `x_out`=0, `busy`=0, `done`=0, `hit_count`=0, `hit_map`=0, delay line cleared.
- Asserting `rst` mid-run aborts immediately: no `done`, and partial results are cleared. The first start after release behaves normally.
- Run timeline, with start sampled at edge 0:
  - `busy` rises after edge 0 and is high for L+Y_LAT cycles.
  - `done` is high in cycle L+Y_LAT+1.
  - A new start is accepted from the cycle after `done`.
- All outputs are registered.
- `x_out` is 0 whenever the block is not in SHIFT.

## Structure
- `p1_ctrl_pkg` holds:
  - the state enum (IDLE/SHIFT/DRAIN/DONE);
  - the Y_LAT maximum constant (3);
  - the length-clamp function.
- One sub-module, `p1_lat_pipe`. It is a Y_LAT-deep shift register carrying {valid, idx}, and it aligns `y_in` sampling with the bit index. The Y_LAT=0 case is a pass-through.
- The FSM, index counter and result registers live in `p1_stream_ctrl`.

## Test plan
- **Reset:** assert `rst` with random inputs → all outputs 0, and `done` never pulses.
- **Mealy model, Y_LAT=0:** `y_in`=`x_out` combinationally; pattern 16'h00FF, length 8 → `busy` for 8 cycles, `done` at cycle 9, `hit_count`=8, `hit_map`=16'h00FF.
- **Moore model, Y_LAT=1:** `y_in` = registered `x_out`; pattern 16'hA5A5, length 0 → L=16, `busy` for 17 cycles, `done` at cycle 18, `hit_count`=8, `hit_map`=16'hA5A5.
- **Length clamp:** length 20 with pattern 16'hFFFF, Y_LAT=0 → L=16, `hit_count`=16. Then length 1 with pattern 16'h0001 → `hit_count`=1, `hit_map`=16'h0001, `done` at cycle 2.
- **Busy protection:** pulse `start` and change `pattern` to 16'h0000 at SHIFT cycle 4 of the 16'h00FF run → the run completes with the original results, and exactly one `done` is produced.
- **Abort:** assert `rst` at SHIFT cycle 3 → outputs 0 at once and no `done`. Release and start pattern 16'h000F, length 4, Y_LAT=0 → `hit_count`=4, `hit_map`=16'h000F.
